// File: rtl/lockstep_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lockstep_checker : cycle-by-cycle DUT vs reference comparator with error capture
// Rev 1.0
// ---------------------------------------------------------------------------
module lockstep_checker #(
  parameter int N_CH         = 4,
  parameter int W            = 34,
  parameter int CNT_W        = 16,
  parameter int ERR_W        = 8,
  parameter int STOP_ON_FAIL = 0,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  run_len,
  input  logic              sample_valid,
  input  logic [N_CH-1:0]   chk_mask,
  input  logic [N_CH*W-1:0] dut_bus,
  input  logic [N_CH*W-1:0] ref_bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_CH-1:0]   mismatch,
  output logic [N_CH-1:0]   fail_vec,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CH_W-1:0]   first_err_ch,
  output logic [W-1:0]      first_err_dut,
  output logic [W-1:0]      first_err_ref
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_run_len;
  logic [CNT_W-1:0]   r_sample_count;
  logic [ERR_W-1:0]   r_err_count;
  logic [N_CH-1:0]    r_mismatch;
  logic [N_CH-1:0]    r_fail_vec;
  logic [CNT_W-1:0]   r_first_idx;
  logic [CH_W-1:0]    r_first_ch;
  logic [W-1:0]       r_first_dut;
  logic [W-1:0]       r_first_ref;

  logic [N_CH-1:0]    w_m;
  logic [CH_W-1:0]    w_low_ch;
  logic [W-1:0]       w_low_dut;
  logic [W-1:0]       w_low_ref;
  logic               w_accept;
  logic               w_start_ok;
  logic               w_last;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Per-channel compare plus lowest-index failing channel selection.
  always_comb begin
    w_m       = '0;
    w_low_ch  = '0;
    w_low_dut = '0;
    w_low_ref = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_m[i] = chk_mask[i] && (dut_bus[i*W +: W] != ref_bus[i*W +: W]);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_m[i]) begin
        w_low_ch  = CH_W'(i);
        w_low_dut = dut_bus[i*W +: W];
        w_low_ref = ref_bus[i*W +: W];
      end
    end
  end

  assign w_accept   = (r_state == ST_RUN) && sample_valid && !abort;
  assign w_start_ok = start && !abort && (r_state != ST_RUN);
  assign w_cnt_inc  = r_sample_count + CNT_W'(1);
  assign w_last     = w_accept && ((w_cnt_inc == r_run_len) ||
                                   ((STOP_ON_FAIL != 0) && (|w_m)));

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) w_state_nxt = (run_len == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (w_last) w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_len      <= '0;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_mismatch     <= '0;
      r_fail_vec     <= '0;
      r_first_idx    <= '0;
      r_first_ch     <= '0;
      r_first_dut    <= '0;
      r_first_ref    <= '0;
    end else if (w_start_ok) begin
      r_run_len      <= run_len;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_mismatch     <= '0;
      r_fail_vec     <= '0;
      r_first_idx    <= '0;
      r_first_ch     <= '0;
      r_first_dut    <= '0;
      r_first_ref    <= '0;
    end else if (w_accept) begin
      r_sample_count <= w_cnt_inc;
      r_mismatch     <= w_m;
      r_fail_vec     <= r_fail_vec | w_m;
      if (|w_m) begin
        if (r_err_count != c_ERR_MAX) r_err_count <= r_err_count + ERR_W'(1);
        // An empty fail vector means this is the run's first mismatching sample.
        if (r_fail_vec == '0) begin
          r_first_idx <= r_sample_count;
          r_first_ch  <= w_low_ch;
          r_first_dut <= w_low_dut;
          r_first_ref <= w_low_ref;
        end
      end
    end else begin
      r_mismatch <= '0;
    end
  end

  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_DONE);
  assign pass          = (r_state == ST_DONE) && (r_err_count == '0);
  assign mismatch      = r_mismatch;
  assign fail_vec      = r_fail_vec;
  assign err_count     = r_err_count;
  assign sample_count  = r_sample_count;
  assign first_err_idx = r_first_idx;
  assign first_err_ch  = r_first_ch;
  assign first_err_dut = r_first_dut;
  assign first_err_ref = r_first_ref;

endmodule
`default_nettype wire
